trisc_datapath: RTL and testbench
=================================

Name: trisc_datapath

Overview:
Register-transfer datapath for the TRISC processor. It sits directly downstream of the three-instruction fetch/decode controller. It consumes that controller's control strobes C0–C4 and C7–C9, and executes them on the PC, MAR, MDR, IR, ACC and Z registers and a 16-word program memory. It feeds the controller back the decoded INC/CLR/JMP lines from the IR opcode field.

Parameters:
DATA_W, 8, width of memory words, MDR, IR and ACC
ADDR_W, 4, width of PC, MAR and address field; memory depth = 2**ADDR_W
OPC_INC, 4'h6, opcode decoded as INC
OPC_CLR, 4'h7, opcode decoded as CLR
OPC_JMP, 4'h8, opcode decoded as JMP

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
C0  input  1  MAR <= PC
C1  input  1  PC <= IR[ADDR_W-1:0] (jump)
C2  input  1  PC <= PC + 1
C3  input  1  MDR <= MEM[MAR]
C4  input  1  IR <= MDR
C7  input  1  ACC <= ACC + 1
C8  input  1  ACC <= 0
C9  input  1  Z <= (next ACC value == 0)
prog_we  input  1  program-memory write enable
prog_addr  input  ADDR_W  program-memory write address
prog_data  input  DATA_W  program-memory write data
INC  output  1  IR opcode == OPC_INC
CLR  output  1  IR opcode == OPC_CLR
JMP  output  1  IR opcode == OPC_JMP
ILL  output  1  IR opcode matches none of the three
pc  output  ADDR_W  program counter
acc  output  DATA_W  accumulator
ir  output  DATA_W  instruction register
z  output  1  zero flag

Behaviour:
- Reset (Clock edge with Reset=1):
  - PC, MAR, MDR, IR and ACC clear to 0; Z sets to 1.
  - Memory contents are not reset.
  - Reset overrides every strobe and prog_we in that cycle.
  - Reset mid-instruction discards all partial state; no memory write occurs that cycle.
- Instruction format: IR[7:4] is the opcode; IR[ADDR_W-1:0] is the address field.
- Decode is combinational from IR; no extra latency.
  - INC/CLR/JMP/ILL are mutually exclusive; exactly one is high at all times.
  - After reset IR=0, so ILL=1 and INC=CLR=JMP=0.
- All strobes take effect at the same rising edge and are independent unless listed below. Every register update has 1-cycle latency.
- PC:
  - C1 has priority over C2; C1 and C2 together give PC <= IR address.
  - C2 wraps 4'hF -> 4'h0.
- MAR: C0 uses the PC value before this edge. C0 with C1/C2 loads the old PC.
- MDR: C3 reads MEM[MAR] using the pre-edge MAR. The read is registered and the result is visible in MDR after the edge.
- IR: C4 loads the pre-edge MDR. C3 and C4 together give IR = old MDR, MDR = new memory word (pipelined).
- ACC:
  - C8 has priority over C7.
  - C7 wraps 8'hFF -> 8'h00.
  - With neither strobe, ACC holds.
- Z:
  - Updates only when C9=1, using the ACC value being written this edge (held value if neither C7 nor C8).
  - Otherwise Z holds.
- Program memory:
  - Single write port with prog_we and synchronous write.
  - Writes are permitted while the datapath runs.
  - C3 read and prog_we write to the same address in one cycle: MDR receives the old word; the new word is stored.
- Undefined strobes (C5, C6) do not exist on this block.
- Decode of ILL has no side effects; the controller defines behaviour on illegal opcodes.

Test Plan:
1. Reset with all strobes high and prog_we=1 -> after edge pc=0, acc=0, ir=0, z=1, ILL=1; memory location unchanged.
2. Load MEM[0]=8'h60; pulse C0, C3, C4 on successive cycles -> ir=8'h60, INC=1; then C2+C7+C9 together -> pc=1, acc=1, z=0.
3. Preload acc=8'hFF via 255 C7 pulses; C7+C9 -> acc=8'h00, z=1; then C7+C8+C9 -> acc=0, z=1 (clear wins).
4. ir=8'h8A; C1+C2 same cycle -> pc=4'hA; C0 in the same cycle -> mar holds the old pc.
5. pc=4'hF, C2 -> pc=0; concurrent C3 with prog_we to mar address (old 8'h70, new 8'h12) -> mdr=8'h70, next read returns 8'h12.
6. ir loaded with 8'h7x then 8'h95 -> CLR=1 then ILL=1, other decode lines 0.

Source files
------------

// File: rtl/trisc_datapath.sv
// ---------------------------------------------------------------------------
// trisc_datapath
//
// Register-transfer datapath for the TRISC processor. The fetch/decode
// controller drives control strobes into this block. This block applies them
// to the PC, MAR, MDR, IR, ACC and Z registers and to a small program memory.
// It returns the decoded opcode lines (INC/CLR/JMP/ILL) taken from the IR.
//
// Handshake / timing contract:
//   There is no valid/ready handshake here. Every strobe is a single-cycle
//   command. It is sampled at the rising edge of Clock, and its register
//   effect is visible right after that edge (1-cycle latency). All strobes
//   sample the pre-edge register values. Strobes are independent of each
//   other unless a priority is listed below.
//
// Ports:
//   Clock        system clock; all state changes on the rising edge
//   Reset        synchronous, active-high; overrides every strobe and prog_we
//   C0           MAR <= PC
//   C1           PC  <= IR address field (wins over C2)
//   C2           PC  <= PC + 1 (wraps)
//   C3           MDR <= MEM[MAR] (registered read, pre-edge MAR)
//   C4           IR  <= MDR (pre-edge MDR)
//   C7           ACC <= ACC + 1 (wraps)
//   C8           ACC <= 0 (wins over C7)
//   C9           Z   <= (value ACC takes at this edge == 0)
//   prog_we      program-memory write enable
//   prog_addr    program-memory write address
//   prog_data    program-memory write data
//   INC/CLR/JMP  IR opcode equals OPC_INC / OPC_CLR / OPC_JMP
//   ILL          IR opcode matches none of the three
//   pc, acc, ir  architectural register views
//   z            zero flag
// ---------------------------------------------------------------------------
module trisc_datapath #(
    parameter int          DATA_W  = 8,
    parameter int          ADDR_W  = 4,
    parameter logic [3:0]  OPC_INC = 4'h6,
    parameter logic [3:0]  OPC_CLR = 4'h7,
    parameter logic [3:0]  OPC_JMP = 4'h8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              C0,
    input  logic              C1,
    input  logic              C2,
    input  logic              C3,
    input  logic              C4,
    input  logic              C7,
    input  logic              C8,
    input  logic              C9,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              INC,
    output logic              CLR,
    output logic              JMP,
    output logic              ILL,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] ir,
    output logic              z
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              z_q,   z_d;

    // Program memory. It is not reset, so its contents survive a processor
    // reset.
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // -----------------------------------------------------------------------
    // Decode: the opcode sits in the top nibble of IR. The address field sits
    // in the low ADDR_W bits. Decode is purely combinational. ILL covers every
    // remaining opcode, so exactly one of the four lines is high at any time.
    // -----------------------------------------------------------------------
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign ir_addr = ir_q[ADDR_W-1:0];

    always_comb begin
        INC = 1'b0;
        CLR = 1'b0;
        JMP = 1'b0;
        ILL = 1'b0;
        if (opcode == OPC_INC) begin
            INC = 1'b1;
        end else if (opcode == OPC_CLR) begin
            CLR = 1'b1;
        end else if (opcode == OPC_JMP) begin
            JMP = 1'b1;
        end else begin
            ILL = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------

    // PC: a jump beats an increment when both are requested.
    always_comb begin
        pc_d = pc_q;
        if (C1) begin
            pc_d = ir_addr;
        end else if (C2) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // MAR captures the pre-edge PC, even when the PC is also changing.
    always_comb begin
        mar_d = mar_q;
        if (C0) begin
            mar_d = pc_q;
        end
    end

    // MDR reads the array directly. The read uses the pre-edge MAR and sees
    // the word stored before any write on this same edge (read-before-write).
    always_comb begin
        mdr_d = mdr_q;
        if (C3) begin
            mdr_d = mem_q[mar_q];
        end
    end

    // IR takes the pre-edge MDR. With C3 in the same cycle this forms a
    // two-stage pipe: IR gets the old word while MDR fetches the next one.
    always_comb begin
        ir_d = ir_q;
        if (C4) begin
            ir_d = mdr_q;
        end
    end

    // ACC: a clear beats an increment.
    always_comb begin
        acc_d = acc_q;
        if (C8) begin
            acc_d = '0;
        end else if (C7) begin
            acc_d = acc_q + DATA_W'(1);
        end
    end

    // Z is tested against the value ACC is about to take. That value is the
    // held ACC when neither C7 nor C8 is active.
    always_comb begin
        z_d = z_q;
        if (C9) begin
            z_d = (acc_d == '0);
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            ir_q  <= '0;
            acc_q <= '0;
            z_q   <= 1'b1;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
            z_q   <= z_d;
        end
    end

    // Program-memory write port. Reset blocks the write, so a reset taken in
    // the middle of loading a program leaves that word unchanged.
    always_ff @(posedge Clock) begin
        if (prog_we && !Reset) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign pc  = pc_q;
    assign acc = acc_q;
    assign ir  = ir_q;
    assign z   = z_q;

endmodule

// File: tb/tb_trisc_datapath.sv
// ---------------------------------------------------------------------------
// Testbench for trisc_datapath.
// A directed vector table walks through one program run: loading memory,
// fetching, jumping, pipelined fetch, decode of every opcode class, PC wrap,
// and a read/write collision. Hand-written sequences follow for the ACC
// wrap, ACC priority and reset-mid-instruction cases.
// Each vector is one clock cycle. Inputs are driven on the falling edge.
// Outputs are checked 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_trisc_datapath;

    // Strobe bit positions inside vec_t.stb
    localparam logic [7:0] S_C0 = 8'h01;
    localparam logic [7:0] S_C1 = 8'h02;
    localparam logic [7:0] S_C2 = 8'h04;
    localparam logic [7:0] S_C3 = 8'h08;
    localparam logic [7:0] S_C4 = 8'h10;
    localparam logic [7:0] S_C7 = 8'h20;
    localparam logic [7:0] S_C8 = 8'h40;
    localparam logic [7:0] S_C9 = 8'h80;

    // Decode expectation encoding {INC,CLR,JMP,ILL}
    localparam logic [3:0] D_INC = 4'b1000;
    localparam logic [3:0] D_CLR = 4'b0100;
    localparam logic [3:0] D_JMP = 4'b0010;
    localparam logic [3:0] D_ILL = 4'b0001;

    typedef struct {
        logic       rst;
        logic [7:0] stb;
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [3:0] pc;
        logic [7:0] acc;
        logic [7:0] ir;
        logic       z;
        logic [3:0] dec;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       C0 = 0, C1 = 0, C2 = 0, C3 = 0, C4 = 0, C7 = 0, C8 = 0, C9 = 0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       INC, CLR, JMP, ILL, z;
    logic [3:0] pc;
    logic [7:0] acc, ir;

    always #5 Clock = ~Clock;

    trisc_datapath dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .C0        (C0),
        .C1        (C1),
        .C2        (C2),
        .C3        (C3),
        .C4        (C4),
        .C7        (C7),
        .C8        (C8),
        .C9        (C9),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .INC       (INC),
        .CLR       (CLR),
        .JMP       (JMP),
        .ILL       (ILL),
        .pc        (pc),
        .acc       (acc),
        .ir        (ir),
        .z         (z)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [7:0] stb,
                                input logic we, input logic [3:0] wa,
                                input logic [7:0] wd, input logic [3:0] epc,
                                input logic [7:0] eacc, input logic [7:0] eir,
                                input logic ez, input logic [3:0] edec);
        vec_t v;
        v.rst = rst; v.stb = stb; v.we = we; v.wa = wa; v.wd = wd;
        v.pc = epc; v.acc = eacc; v.ir = eir; v.z = ez; v.dec = edec;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input vec_t v, input int idx);
        @(negedge Clock);
        Reset     = v.rst;
        C0        = v.stb[0];
        C1        = v.stb[1];
        C2        = v.stb[2];
        C3        = v.stb[3];
        C4        = v.stb[4];
        C7        = v.stb[5];
        C8        = v.stb[6];
        C9        = v.stb[7];
        prog_we   = v.we;
        prog_addr = v.wa;
        prog_data = v.wd;
        @(posedge Clock);
        #1;
        check("pc",  idx, {4'h0, pc}, {4'h0, v.pc});
        check("acc", idx, acc, v.acc);
        check("ir",  idx, ir, v.ir);
        check("z",   idx, {7'h0, z}, {7'h0, v.z});
        check("dec", idx, {4'h0, INC, CLR, JMP, ILL}, {4'h0, v.dec});
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[$];

    initial begin
        // ---- reset and program load ----
        tbl.push_back(mk(1, 8'h00, 0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00, 1, D_ILL));
        tbl.push_back(mk(0, 8'h00, 1, 4'h0, 8'h60, 4'h0, 8'h00, 8'h00, 1, D_ILL));
        tbl.push_back(mk(0, 8'h00, 1, 4'h1, 8'h83, 4'h0, 8'h00, 8'h00, 1, D_ILL));
        tbl.push_back(mk(0, 8'h00, 1, 4'h3, 8'h5A, 4'h0, 8'h00, 8'h00, 1, D_ILL));
        // Reset with every strobe and a write to MEM[3]: the write must be dropped.
        tbl.push_back(mk(1, 8'hFF, 1, 4'h3, 8'hFF, 4'h0, 8'h00, 8'h00, 1, D_ILL));
        // ---- fetch the INC at address 0, then execute it ----
        tbl.push_back(mk(0, S_C0, 0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00, 1, D_ILL));
        tbl.push_back(mk(0, S_C3, 0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00, 1, D_ILL));
        tbl.push_back(mk(0, S_C4, 0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h60, 1, D_INC));
        tbl.push_back(mk(0, S_C2|S_C7|S_C9, 0, 4'h0, 8'h00, 4'h1, 8'h01, 8'h60, 0, D_INC));
        // ---- fetch JMP 3 while writing more program words ----
        tbl.push_back(mk(0, S_C0, 1, 4'h4, 8'h8A, 4'h1, 8'h01, 8'h60, 0, D_INC));
        tbl.push_back(mk(0, S_C3, 1, 4'hA, 8'h7C, 4'h1, 8'h01, 8'h60, 0, D_INC));
        tbl.push_back(mk(0, S_C4, 1, 4'hC, 8'h95, 4'h1, 8'h01, 8'h83, 0, D_JMP));
        tbl.push_back(mk(0, S_C1, 1, 4'hE, 8'h70, 4'h3, 8'h01, 8'h83, 0, D_JMP));
        // ---- read MEM[3]: still 5A because the write under reset was dropped ----
        tbl.push_back(mk(0, S_C0, 0, 4'h0, 8'h00, 4'h3, 8'h01, 8'h83, 0, D_JMP));
        tbl.push_back(mk(0, S_C3, 0, 4'h0, 8'h00, 4'h3, 8'h01, 8'h83, 0, D_JMP));
        tbl.push_back(mk(0, S_C4, 0, 4'h0, 8'h00, 4'h3, 8'h01, 8'h5A, 0, D_ILL));
        // ---- fetch 8A from address 4 ----
        tbl.push_back(mk(0, S_C2, 0, 4'h0, 8'h00, 4'h4, 8'h01, 8'h5A, 0, D_ILL));
        tbl.push_back(mk(0, S_C0, 0, 4'h0, 8'h00, 4'h4, 8'h01, 8'h5A, 0, D_ILL));
        tbl.push_back(mk(0, S_C3, 0, 4'h0, 8'h00, 4'h4, 8'h01, 8'h5A, 0, D_ILL));
        tbl.push_back(mk(0, S_C4, 0, 4'h0, 8'h00, 4'h4, 8'h01, 8'h8A, 0, D_JMP));
        // C0+C1+C2: PC takes A from IR, MAR takes the old PC (4).
        tbl.push_back(mk(0, S_C0|S_C1|S_C2, 0, 4'h0, 8'h00, 4'hA, 8'h01, 8'h8A, 0, D_JMP));
        // The read from MAR returns MEM[4]=8A. MEM[A] would give 7C.
        tbl.push_back(mk(0, S_C3, 0, 4'h0, 8'h00, 4'hA, 8'h01, 8'h8A, 0, D_JMP));
        tbl.push_back(mk(0, S_C0, 0, 4'h0, 8'h00, 4'hA, 8'h01, 8'h8A, 0, D_JMP));
        // Pipelined C3+C4: IR gets old MDR (8A), MDR fetches MEM[A]=7C.
        tbl.push_back(mk(0, S_C3|S_C4, 0, 4'h0, 8'h00, 4'hA, 8'h01, 8'h8A, 0, D_JMP));
        tbl.push_back(mk(0, S_C4, 0, 4'h0, 8'h00, 4'hA, 8'h01, 8'h7C, 0, D_CLR));
        // ---- C1 on a CLR word still loads the address field (C) ----
        tbl.push_back(mk(0, S_C1, 0, 4'h0, 8'h00, 4'hC, 8'h01, 8'h7C, 0, D_CLR));
        tbl.push_back(mk(0, S_C0, 0, 4'h0, 8'h00, 4'hC, 8'h01, 8'h7C, 0, D_CLR));
        tbl.push_back(mk(0, S_C3, 0, 4'h0, 8'h00, 4'hC, 8'h01, 8'h7C, 0, D_CLR));
        tbl.push_back(mk(0, S_C4, 0, 4'h0, 8'h00, 4'hC, 8'h01, 8'h95, 0, D_ILL));
        // ---- PC wrap and read/write collision at MAR=E ----
        tbl.push_back(mk(0, S_C2, 0, 4'h0, 8'h00, 4'hD, 8'h01, 8'h95, 0, D_ILL));
        tbl.push_back(mk(0, S_C2, 0, 4'h0, 8'h00, 4'hE, 8'h01, 8'h95, 0, D_ILL));
        tbl.push_back(mk(0, S_C0|S_C2, 0, 4'h0, 8'h00, 4'hF, 8'h01, 8'h95, 0, D_ILL));
        tbl.push_back(mk(0, S_C2|S_C3, 1, 4'hE, 8'h12, 4'h0, 8'h01, 8'h95, 0, D_ILL));
        tbl.push_back(mk(0, S_C3|S_C4, 0, 4'h0, 8'h00, 4'h0, 8'h01, 8'h70, 0, D_CLR));
        tbl.push_back(mk(0, S_C4, 0, 4'h0, 8'h00, 4'h0, 8'h01, 8'h12, 0, D_ILL));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // ---- ACC: clear without C9 leaves Z held, then count to FF ----
        apply(mk(0, S_C8, 0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h12, 0, D_ILL), 100);
        for (int i = 1; i <= 255; i++) begin
            apply(mk(0, S_C7, 0, 4'h0, 8'h00, 4'h0, 8'(i), 8'h12, 0, D_ILL), 1000 + i);
        end
        // Wrap FF -> 00 and set Z from the new value.
        apply(mk(0, S_C7|S_C9, 0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h12, 1, D_ILL), 101);
        // Increment without C9: Z holds.
        apply(mk(0, S_C7, 0, 4'h0, 8'h00, 4'h0, 8'h01, 8'h12, 1, D_ILL), 102);
        // C9 alone tests the held ACC (1).
        apply(mk(0, S_C9, 0, 4'h0, 8'h00, 4'h0, 8'h01, 8'h12, 0, D_ILL), 103);
        // Clear beats increment, and Z sees the cleared value.
        apply(mk(0, S_C7|S_C8|S_C9, 0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h12, 1, D_ILL), 104);

        // ---- reset mid-instruction discards partial state ----
        apply(mk(0, S_C7|S_C9|S_C2, 0, 4'h0, 8'h00, 4'h1, 8'h01, 8'h12, 0, D_ILL), 105);
        apply(mk(1, S_C0|S_C3|S_C4|S_C7, 1, 4'h5, 8'hEE, 4'h0, 8'h00, 8'h00, 1, D_ILL), 106);
        // MDR was cleared too: IR <= MDR gives 0.
        apply(mk(0, S_C4, 0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00, 1, D_ILL), 107);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
